// File: rtl/divu_hilo_unit_pkg.sv
// Shared constants for the unsigned divide unit with HI/LO result registers.
// Holds the function codes it shares with the ALU (DIVU/MFHI/MFLO), the FSM state
// encoding and the default operand width.
package divu_hilo_unit_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [5:0] FN_DIVU = 6'd27;
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in       partial remainder before the step
//   dividend_bit next dividend bit, shifted in at the LSB
//   divisor      divisor
//   rem_out      partial remainder after the step
//   q_bit        quotient bit produced by the step
module divu_step
  import divu_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_in, dividend_bit};
    trial   = shifted - {1'b0, divisor};
    // Unsigned compare instead of the trial sign bit keeps divide-by-zero well
    // defined (the shifted value always "fits" a zero divisor).
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned divider with HI (remainder) / LO (quotient) registers.
// A DIVU code in IDLE captures A/B; WIDTH restoring steps follow, then one DONE
// cycle at whose closing edge HI/LO are written.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active low
//   ctrl   function code (DIVU starts, MFHI/MFLO select result, others no-op)
//   A, B   unsigned dividend / divisor
//   result HI for MFHI, LO for MFLO, zero otherwise (combinational)
//   busy   high in RUN and DONE
//   done   high for the single DONE cycle
module divu_hilo_unit
  import divu_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] dvd, dvd_next;   // dividend, consumed MSB first by shifting left
  logic [WIDTH-1:0] dvs, dvs_next;
  logic [WIDTH-1:0] rem, rem_next;
  logic [WIDTH-1:0] quo, quo_next;
  logic [WIDTH-1:0] hi, hi_next;
  logic [WIDTH-1:0] lo, lo_next;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  divu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in      (rem),
    .dividend_bit(dvd[WIDTH-1]),
    .divisor     (dvs),
    .rem_out     (step_rem),
    .q_bit       (step_q)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    dvd_next   = dvd;
    dvs_next   = dvs;
    rem_next   = rem;
    quo_next   = quo;
    hi_next    = hi;
    lo_next    = lo;
    case (state)
      ST_IDLE: begin
        if (ctrl == FN_DIVU) begin
          dvd_next   = A;
          dvs_next   = B;
          rem_next   = '0;
          quo_next   = '0;
          count_next = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        rem_next   = step_rem;
        quo_next   = {quo[WIDTH-2:0], step_q};
        dvd_next   = dvd << 1;
        count_next = count + 1'b1;
        if (count == CNT_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        // DIVU here is deliberately ignored; only IDLE accepts a new operation.
        hi_next    = rem;
        lo_next    = quo;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      dvd   <= dvd_next;
      dvs   <= dvs_next;
      rem   <= rem_next;
      quo   <= quo_next;
      hi    <= hi_next;
      lo    <= lo_next;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_comb begin
    result = '0;
    case (ctrl)
      FN_MFHI: result = hi;
      FN_MFLO: result = lo;
      default: result = '0;
    endcase
  end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Self-checking bench for divu_hilo_unit: directed cases, randomized operands
// against an arithmetic reference (A/B, A%B, divide-by-zero rule), busy-time
// DIVU rejection, reset abort and HI/LO stability during a division.
module tb_divu_hilo_unit;
  import divu_hilo_unit_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   ctrl;
  logic [W-1:0] A, B, result;
  logic         busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  divu_hilo_unit #(
    .WIDTH(W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ctrl  (ctrl),
    .A     (A),
    .B     (B),
    .result(result),
    .busy  (busy),
    .done  (done)
  );

  // mode 0: idle ctrl during run; 1: read MFLO every cycle; 2: hold DIVU with
  // changing operands; 3: single DIVU 9/3 injected at cycle 5.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                         input string tag);
    int lat;
    int pulses;
    logic [W-1:0] q, r;
    q = (b == '0) ? '1 : a / b;
    r = (b == '0) ? a : a % b;
    @(negedge clk);
    ctrl = FN_DIVU; A = a; B = b;
    @(posedge clk);
    #1;
    A = $urandom; B = $urandom;
    ctrl = (mode == 1) ? FN_MFLO : (mode == 2) ? FN_DIVU : 6'd0;
    lat = 1;
    pulses = 0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_capture got=%b want=1", tag, busy);
    else n_pass++;
    while (busy === 1'b1 && lat < 100) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
      if (mode == 1) begin
        n_checks++;
        if (result !== exp_lo)
          $display("FAIL %s mflo_during_run cyc=%0d got=%h want=%h", tag, lat, result, exp_lo);
        else n_pass++;
      end
      if (mode == 2) begin A = $urandom; B = $urandom; end
      if (mode == 3) begin
        ctrl = (lat == 5) ? FN_DIVU : 6'd0;
        A = 9; B = 3;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    ctrl = 6'd0;
    n_checks++;
    if (lat != int'(W + 2)) $display("FAIL %s latency got=%0d want=%0d", tag, lat, W + 2);
    else n_pass++;
    n_checks++;
    if (pulses != 1) $display("FAIL %s done_pulses got=%0d want=1", tag, pulses);
    else n_pass++;
    exp_hi = r;
    exp_lo = q;
    ctrl = FN_MFHI;
    #1;
    n_checks++;
    if (result !== exp_hi) $display("FAIL %s mfhi a=%h b=%h got=%h want=%h", tag, a, b, result, exp_hi);
    else n_pass++;
    ctrl = FN_MFLO;
    #1;
    n_checks++;
    if (result !== exp_lo) $display("FAIL %s mflo a=%h b=%h got=%h want=%h", tag, a, b, result, exp_lo);
    else n_pass++;
    ctrl = 6'd0;
    #1;
    n_checks++;
    if (result !== '0) $display("FAIL %s noop_result got=%h want=0", tag, result);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b0; ctrl = 6'd0; A = '0; B = '0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_flags got=%b%b want=00", busy, done);
    else n_pass++;
    ctrl = FN_MFHI;
    #1;
    n_checks++;
    if (result !== '0) $display("FAIL reset_hi got=%h want=0", result);
    else n_pass++;
    ctrl = FN_MFLO;
    #1;
    n_checks++;
    if (result !== '0) $display("FAIL reset_lo got=%h want=0", result);
    else n_pass++;
    ctrl = 6'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_directed;
    run_div(32'd100, 32'd7, 0, "div_100_7");
    run_div(32'hFFFF_FFFF, 32'd1, 0, "div_max_1");
    run_div(32'd3, 32'd10, 0, "div_3_10");
    run_div(32'd5, 32'd0, 0, "div_by_zero");
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = '0;
        default: b = a >> $urandom_range(0, 31);
      endcase
      run_div(a, b, 0, "random");
    end
  endtask

  task automatic test_ignore_busy;
    run_div(32'd100, 32'd7, 3, "ignore_inject");
    run_div(32'd1000, 32'd33, 2, "ignore_hold");
  endtask

  task automatic test_mflo_during_run;
    run_div(32'd100, 32'd7, 0, "prime_100_7");
    run_div(32'd9, 32'd3, 1, "mflo_run_9_3");
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    ctrl = FN_DIVU; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1;
    ctrl = 6'd0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags got=%b%b want=00", busy, done);
    else n_pass++;
    ctrl = FN_MFHI;
    #1;
    n_checks++;
    if (result !== '0) $display("FAIL abort_hi got=%h want=0", result);
    else n_pass++;
    ctrl = 6'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    ctrl = FN_MFLO;
    #1;
    n_checks++;
    if (result !== '0 || busy !== 1'b0)
      $display("FAIL abort_no_partial lo=%h busy=%b want lo=0 busy=0", result, busy);
    else n_pass++;
    ctrl = 6'd0;
    run_div(32'd50, 32'd6, 0, "after_abort_50_6");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_mflo_during_run();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divu_hilo_unit.md
DIVU_HILO_UNIT -- requirements
Module: divu_hilo_unit

Interface
REQ-001 SHALL provide parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL provide port: clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL provide port: rst  input  1  asynchronous reset, active-low (rst=0 resets).
REQ-004 SHALL provide port: ctrl  input  6  function code: 27=DIVU, 16=MFHI, 18=MFLO; all other codes are no-op.
REQ-005 SHALL provide port: A  input  WIDTH  unsigned dividend.
REQ-006 SHALL provide port: B  input  WIDTH  unsigned divisor.
REQ-007 SHALL provide port: result  output  WIDTH  HI/LO readout.
REQ-008 SHALL provide port: busy  output  1  high while a division is in progress.
REQ-009 SHALL provide port: done  output  1  one-cycle pulse when HI/LO are updated.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 IDLE: on a clk edge with ctrl==27, SHALL capture A and B, clear the partial remainder, set count=0, and enter RUN.
REQ-012 RUN: SHALL perform one restoring shift-subtract step per cycle, MSB of dividend first, for exactly WIDTH cycles, then enter DONE.
REQ-013 Each step SHALL form a WIDTH+1-bit trial difference (rem<<1 | next dividend bit) - divisor; a non-negative result sets the quotient bit and replaces rem.
REQ-014 DONE: SHALL write HI=remainder and LO=quotient, assert done for that cycle, and return to IDLE.
REQ-015 HI/LO SHALL be valid WIDTH+2 clk edges after the capture edge (34 for WIDTH=32).
REQ-016 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-017 ctrl==27 while busy SHALL be ignored; no restart and no re-capture occur.
REQ-018 A/B changes after the capture edge SHALL NOT affect the operation in progress.
REQ-019 HI/LO SHALL hold their previous values throughout RUN and change only in DONE.
REQ-020 result SHALL be combinational: HI when ctrl==16, LO when ctrl==18, 0 otherwise; it is readable in any state.
REQ-021 Divide by zero SHALL complete in normal latency with LO=all-ones and HI=A; no error flag.
REQ-022 ctrl==27 in the DONE cycle SHALL be ignored; a new DIVU is accepted only from IDLE.

Reset
REQ-023 rst=0 SHALL immediately force state=IDLE, HI=0, LO=0, count=0, remainder/quotient/divisor registers=0, busy=0, done=0.
REQ-024 Reset during RUN SHALL abort the division; no partial value reaches HI/LO.
REQ-025 After rst deasserts, the first clk edge with ctrl==27 SHALL start a division normally.

Structure
REQ-026 A shared package SHALL hold FN_DIVU=6'd27, FN_MFHI=6'd16, FN_MFLO=6'd18, the FSM state encoding, and the WIDTH default.
REQ-027 One sub-module, divu_step, SHALL implement the combinational single restoring step (rem_in, dividend bit, divisor -> rem_out, q_bit).
REQ-028 The block SHALL be standalone and sit alongside the existing ALU, sharing its ctrl/A/B/result convention.

Verification
REQ-029 DIVU A=100, B=7 -> after 34 edges: MFHI=2, MFLO=14; done pulses once.
REQ-030 DIVU A=0xFFFFFFFF, B=1 -> MFLO=0xFFFFFFFF, MFHI=0.
REQ-031 DIVU A=3, B=10 -> MFLO=0, MFHI=3; DIVU A=5, B=0 -> MFLO=0xFFFFFFFF, MFHI=5.
REQ-032 Start DIVU 100/7, then ctrl=27 with A=9, B=3 at cycle 5 -> ignored; result is still HI=2, LO=14.
REQ-033 Start DIVU, assert rst=0 at cycle 10 -> busy=0 and HI=LO=0 at once; next DIVU 50/6 -> HI=2, LO=8.
REQ-034 Prior HI=2, LO=14, then start DIVU 9/3 and read MFLO during RUN -> returns 14 until DONE, then 3.
